// File: rtl/imem_pkg.sv
// Shared constants and loader state encoding for the byte-addressed instruction
// memory and its write-side loader.
package imem_pkg;

  localparam int MEM_DEPTH = 16384;
  localparam int ADDR_W    = $clog2(MEM_DEPTH);
  localparam int CNT_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_ACCEPT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } ld_state_t;

endpackage

// File: rtl/imem_loader_serializer.sv
// Latches one 32-bit instruction word and presents it as four bytes, MSB first,
// with the current byte index and a last-byte flag.
module word_byte_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        advance,
  output logic [7:0]  data_byte,
  output logic [1:0]  idx,
  output logic        last
);

  logic [31:0] word_p0;
  logic [1:0]  idx_q;

  always_ff @(posedge clk) begin
    if (load) word_p0 <= word;
  end

  always_ff @(posedge clk) begin
    if (rst)          idx_q <= 2'd0;
    else if (load)    idx_q <= 2'd0;
    else if (advance) idx_q <= idx_q + 2'd1;
  end

  always_comb begin
    data_byte = word_p0[31:24];
    case (idx_q)
      2'd0:    data_byte = word_p0[31:24];
      2'd1:    data_byte = word_p0[23:16];
      2'd2:    data_byte = word_p0[15:8];
      default: data_byte = word_p0[7:0];
    endcase
  end

  assign idx  = idx_q;
  assign last = (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit instruction words into the byte-wide instruction memory,
// big-endian, holding the CPU while a program image is loaded.
module imem_loader #(
  parameter int MEM_DEPTH = imem_pkg::MEM_DEPTH,
  parameter int ADDR_W    = imem_pkg::ADDR_W,
  parameter int CNT_W     = imem_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err_range
);

  import imem_pkg::*;

  // End address is formed in 33 bits so a base near 2^32 cannot wrap into range.
  function automatic logic range_bad(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
    logic [32:0] end_a;
    end_a = {1'b0, base} + {{(31-CNT_W){1'b0}}, cnt, 2'b00};
    return (base[1:0] != 2'b00) || (end_a > 33'(MEM_DEPTH));
  endfunction

  ld_state_t         state, state_nxt;
  logic [31:0]       base_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remaining_q;

  logic       ser_load, ser_adv, ser_last;
  logic [7:0] ser_byte;
  logic [1:0] ser_idx;

  word_byte_serializer u_ser (
    .clk       (clk),
    .rst       (rst),
    .load      (ser_load),
    .word      (in_word),
    .advance   (ser_adv),
    .data_byte (ser_byte),
    .idx       (ser_idx),
    .last      (ser_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            base_q <= base_addr;
            cnt_q  <= word_count;
          end
        end
        ST_CHECK: begin
          addr_q      <= base_q[ADDR_W-1:0];
          remaining_q <= cnt_q;
        end
        ST_WRITE: begin
          if (ser_last) begin
            addr_q      <= addr_q + ADDR_W'(4);
            remaining_q <= remaining_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    err_range = 1'b0;
    ser_load  = 1'b0;
    ser_adv   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_CHECK;
      end
      ST_CHECK: begin
        busy = 1'b1;
        if (range_bad(base_q, cnt_q)) state_nxt = ST_ERR;
        else if (cnt_q == '0)         state_nxt = ST_DONE;
        else                          state_nxt = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        if (in_valid) begin
          ser_load  = 1'b1;
          state_nxt = ST_WRITE;
        end
      end
      ST_WRITE: begin
        busy    = 1'b1;
        mem_we  = 1'b1;
        ser_adv = 1'b1;
        if (ser_last) state_nxt = (remaining_q == CNT_W'(1)) ? ST_DONE : ST_ACCEPT;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        err_range = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address and data are forced to zero outside WRITE so idle outputs stay quiet.
  assign mem_addr  = mem_we ? (addr_q + ADDR_W'(ser_idx)) : '0;
  assign mem_wdata = mem_we ? ser_byte : 8'h00;
  assign cpu_hold  = busy;

endmodule

// File: tb/tb_imem_loader.sv
// Directed and randomized load requests for imem_loader, checked against an
// expected byte-write list and request-level timing derived from the load rules.
module tb_imem_loader;

  localparam int MEM_DEPTH = 16384;
  localparam int ADDR_W    = 14;
  localparam int CNT_W     = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [31:0]       base_addr;
  logic [CNT_W-1:0]  word_count;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_word;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err_range;

  imem_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err_range  (err_range)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int ndone  = 0;
  int nerr   = 0;
  int nready = 0;

  logic [21:0] exp_q[$];
  logic [31:0] pend[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every byte write must be the next entry of the expected list.
  always @(negedge clk) begin
    if (done)      ndone++;
    if (err_range) nerr++;
    if (in_ready)  nready++;
    if (mem_we) begin
      if (exp_q.size() == 0) chk("stray_write", 32'(mem_we), 32'd0);
      else                   chk("write_addr_data", 32'({mem_addr, mem_wdata}), 32'(exp_q.pop_front()));
    end
    if (!rst) chk("hold_eq_busy", 32'(cpu_hold), 32'(busy));
  end

  task automatic run_req(input logic [31:0] base, input int cnt, input int gap, input bit poke);
    logic [31:0] w[$];
    bit bad;
    int c0, d0, e0, r0, t, g, gapsum;
    bad = ((base % 4) != 0) || ((longint'(base) + 4 * longint'(cnt)) > MEM_DEPTH);
    for (int i = 0; i < cnt; i++) w.push_back((pend.size() == cnt) ? pend[i] : $urandom);
    pend.delete();
    if (!bad)
      for (int i = 0; i < cnt; i++)
        for (int b = 0; b < 4; b++)
          exp_q.push_back({14'(base + 4 * i + b), 8'((w[i] >> (24 - 8 * b)) & 32'hff)});
    gapsum = 0;
    d0 = ndone; e0 = nerr; r0 = nready;
    @(posedge clk) #1;
    start      = 1'b1;
    base_addr  = base;
    word_count = CNT_W'(cnt);
    in_valid   = (cnt > 0) && !bad;
    in_word    = (cnt > 0) ? w[0] : $urandom;
    c0 = cyc;
    @(posedge clk) #1;
    start     = 1'b0;
    base_addr = $urandom;
    word_count = CNT_W'($urandom);
    @(negedge clk);
    chk("busy_in_check", 32'(busy), 32'd1);
    if (bad || cnt == 0) begin
      @(negedge clk);
      chk(bad ? "err_pulse" : "done_pulse", 32'(bad ? err_range : done), 32'd1);
      chk("busy_after", 32'(busy), 32'd0);
      @(negedge clk);
      chk("pulse_width", 32'(bad ? err_range : done), 32'd0);
      #1;
      chk("done_count", 32'(ndone - d0), bad ? 32'd0 : 32'd1);
      chk("err_count", 32'(nerr - e0), bad ? 32'd1 : 32'd0);
      chk("no_ready", 32'(nready - r0), 32'd0);
    end else begin
      for (int i = 0; i < cnt; i++) begin
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 40);
        chk("accept_ready", 32'(in_ready), 32'd1);
        @(posedge clk) #1;
        g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
        if (i + 1 < cnt) begin
          in_word  = w[i + 1];
          in_valid = (g == 0);
        end else begin
          in_valid = 1'b0;
          g = 0;
        end
        if (poke && i == 0) begin
          start      = 1'b1;
          base_addr  = 32'd200;
          word_count = CNT_W'(1);
          @(posedge clk) #1;
          start = 1'b0;
        end
        if (g > 0) begin
          gapsum += g;
          t = 0;
          do begin @(negedge clk); t++; end while (!in_ready && t < 40);
          chk("gap_ready", 32'(in_ready), 32'd1);
          chk("gap_no_we", 32'(mem_we), 32'd0);
          repeat (g - 1) begin
            @(negedge clk);
            chk("gap_no_we", 32'(mem_we), 32'd0);
          end
          @(posedge clk) #1;
          in_valid = 1'b1;
        end
      end
      t = 0;
      do begin @(negedge clk); t++; end while (!done && t < 60);
      chk("done_seen", 32'(done), 32'd1);
      chk("done_latency", 32'(cyc - c0), 32'(2 + 5 * cnt + gapsum));
      chk("busy_at_done", 32'(busy), 32'd0);
      @(negedge clk);
      chk("done_width", 32'(done), 32'd0);
      #1;
      chk("writes_left", 32'(exp_q.size()), 32'd0);
      chk("done_count", 32'(ndone - d0), 32'd1);
      chk("err_count", 32'(nerr - e0), 32'd0);
    end
  endtask

  initial begin
    int t, d0, bw, c;
    logic [31:0] wr;
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    in_valid = 1'b0; in_word = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err_range), 32'd0);
    @(posedge clk) #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ready", 32'(in_ready), 32'd0);

    pend.push_back(32'h49400000);
    run_req(32'd0, 1, 0, 1'b0);
    pend.push_back(32'h24000005);
    pend.push_back(32'h2401000a);
    run_req(32'd100, 2, 3, 1'b0);
    run_req(32'd16380, 2, 0, 1'b0);
    run_req(32'd2, 1, 0, 1'b0);
    run_req(32'd0, 0, 0, 1'b0);
    run_req(32'd16376, 2, 0, 1'b0);
    run_req(32'd16380, 1, 0, 1'b0);
    run_req(32'hFFFFFFFC, 1, 0, 1'b0);
    run_req(32'd1, 0, 0, 1'b0);

    // Reset during the second byte of a word: two bytes land, then silence.
    wr = $urandom;
    d0 = ndone;
    for (int b = 0; b < 2; b++) exp_q.push_back({14'(b), 8'((wr >> (24 - 8 * b)) & 32'hff)});
    @(posedge clk) #1;
    start = 1'b1; base_addr = 32'd0; word_count = CNT_W'(1);
    in_valid = 1'b1; in_word = wr;
    @(posedge clk) #1 start = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!mem_we && t < 20);
    chk("rst_mid_first_we", 32'(mem_we), 32'd1);
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 begin rst = 1'b0; in_valid = 1'b0; end
    @(negedge clk);
    chk("rst_mid_we", 32'(mem_we), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd0);
    #1;
    chk("rst_mid_writes", 32'(exp_q.size()), 32'd0);
    chk("rst_mid_no_done", 32'(ndone - d0), 32'd0);
    run_req(32'd0, 1, 0, 1'b0);

    // Start pulsed mid-load must be ignored.
    run_req(32'd64, 2, 0, 1'b1);

    for (int k = 0; k < 8; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        run_req($urandom, int'($urandom_range(0, 65535)), -1, 1'b0);
      end else begin
        c  = int'($urandom_range(1, 4));
        bw = int'($urandom_range(0, (MEM_DEPTH - 4 * c) / 4));
        run_req(32'(4 * bw), c, -1, k[0]);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
